// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter_if
// Description : Bus bundle between the CPU memory stage, an external master,
//               the data-memory arbiter and the single-port data memory.
//               slave  = arbiter side, master = requesters / memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_re;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Shares the single-port data memory between the CPU memory
//               stage (priority) and an external master. An aging counter
//               forces a one-cycle ext slot (CPU stalled) after MAX_WAIT
//               consecutive blocked cycles.
//               Optional macro DM_ARB_STATS_EN adds saturating grant / stall
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  dm_arbiter_if.slave      bus
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]      stat_ext_cnt,
  output logic [15:0]      stat_stall_cnt
`endif
);

  typedef enum logic [0:0] {
    CPU_OWN = 1'b0,
    FORCE   = 1'b1
  } state_t;

  // Last blocked cycle count before the forced slot is taken.
  localparam logic [7:0] c_wait_limit = 8'(MAX_WAIT - 1);

  state_t        state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          ext_rvalid_q, ext_rvalid_d;

  logic          w_cpu_act;
  logic          w_ext_gnt;
  logic          w_mem_re;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  // Arbitration: memory mux, ext grant, aging counter and next state.
  always_comb begin
    w_cpu_act    = bus.cpu_re | bus.cpu_we;
    w_ext_gnt    = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = bus.cpu_addr;
    w_mem_wdata  = bus.cpu_wdata;
    state_d      = CPU_OWN;
    wait_cnt_d   = 8'd0;

    unique case (state_q)
      CPU_OWN: begin
        if (w_cpu_act) begin
          w_mem_re = bus.cpu_re;
          w_mem_we = bus.cpu_we;
        end else if (bus.ext_req) begin
          w_ext_gnt   = 1'b1;
          w_mem_re    = ~bus.ext_we;
          w_mem_we    = bus.ext_we;
          w_mem_addr  = bus.ext_addr;
          w_mem_wdata = bus.ext_wdata;
        end
        // Only a request that is left waiting ages; anything else restarts.
        if (bus.ext_req && !w_ext_gnt) begin
          if (wait_cnt_q == c_wait_limit) begin
            state_d = FORCE;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      FORCE: begin
        // CPU request is ignored; a withdrawn ext request just idles the slot.
        if (bus.ext_req) begin
          w_ext_gnt   = 1'b1;
          w_mem_re    = ~bus.ext_we;
          w_mem_we    = bus.ext_we;
          w_mem_addr  = bus.ext_addr;
          w_mem_wdata = bus.ext_wdata;
        end
      end
      default: begin
        state_d = CPU_OWN;
      end
    endcase

    ext_rvalid_d = w_ext_gnt & ~bus.ext_we;
  end

  // State, aging counter and ext read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CPU_OWN;
      wait_cnt_q   <= 8'd0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  // cpu_stall comes straight from the state flop, so ext_req never reaches it
  // combinationally.
  assign bus.cpu_stall  = (state_q == FORCE);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = bus.mem_rdata;
  assign bus.ext_gnt    = w_ext_gnt;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.mem_re     = w_mem_re;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;

`ifdef DM_ARB_STATS_EN
  logic [15:0] stat_ext_cnt_q, stat_ext_cnt_d;
  logic [15:0] stat_stall_cnt_q, stat_stall_cnt_d;

  // Saturating counters of ext grants and stalled cycles.
  always_comb begin
    stat_ext_cnt_d   = stat_ext_cnt_q;
    stat_stall_cnt_d = stat_stall_cnt_q;
    if (w_ext_gnt && (stat_ext_cnt_q != 16'hFFFF)) begin
      stat_ext_cnt_d = stat_ext_cnt_q + 16'd1;
    end
    if ((state_q == FORCE) && (stat_stall_cnt_q != 16'hFFFF)) begin
      stat_stall_cnt_d = stat_stall_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ext_cnt_q   <= 16'd0;
      stat_stall_cnt_q <= 16'd0;
    end else begin
      stat_ext_cnt_q   <= stat_ext_cnt_d;
      stat_stall_cnt_q <= stat_stall_cnt_d;
    end
  end

  assign stat_ext_cnt   = stat_ext_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Self-checking bench for dm_arbiter: directed scenarios plus
//               randomized traffic against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DM_ARB_STATS_EN
  logic [15:0] stat_ext_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave)
`ifdef DM_ARB_STATS_EN
    ,
    .stat_ext_cnt   (stat_ext_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in single-port data memory with synchronous read.
  logic [DW-1:0] dm_mem [0:255] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= dm_mem[bus.mem_addr[7:0]];
    if (bus.mem_we) dm_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] shadow [0:255] = '{default: 16'h0000};
  int            m_blocked;   // consecutive cycles ext has waited
  bit            m_force;     // this cycle is the guaranteed ext slot
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  bit            exp_gnt, exp_re, exp_we, exp_stall, exp_rvalid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  task automatic model_reset();
    m_blocked = 0;
    m_force   = 0;
    m_rvalid  = 0;
  endtask

  // What the memory port should see this cycle given the current requests.
  task automatic model_eval();
    exp_stall  = m_force;
    exp_rvalid = m_rvalid;
    exp_gnt    = 0;
    exp_re     = 0;
    exp_we     = 0;
    exp_addr   = bus.cpu_addr;
    exp_wdata  = bus.cpu_wdata;
    if (!m_force && (bus.cpu_re || bus.cpu_we)) begin
      exp_re = bus.cpu_re;
      exp_we = bus.cpu_we;
    end else if (bus.ext_req) begin
      exp_gnt   = 1;
      exp_re    = !bus.ext_we;
      exp_we    = bus.ext_we;
      exp_addr  = bus.ext_addr;
      exp_wdata = bus.ext_wdata;
    end
  endtask

  // Advance the model across a clock edge.
  task automatic model_commit();
    m_rvalid = exp_gnt && !bus.ext_we;
    if (m_rvalid) m_rdata = shadow[bus.ext_addr[7:0]];
    if (exp_we) shadow[exp_addr[7:0]] = exp_wdata;
    if (m_force) begin
      m_force   = 0;
      m_blocked = 0;
    end else if (bus.ext_req && !exp_gnt) begin
      m_blocked++;
      if (m_blocked == MAX_WAIT) begin
        m_force   = 1;
        m_blocked = 0;
      end
    end else begin
      m_blocked = 0;
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_re    = 0;
    bus.cpu_we    = 0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ext_req   = 0;
    bus.ext_we    = 0;
    bus.ext_addr  = '0;
    bus.ext_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    n_checks++;
    if (bus.cpu_stall !== 1'b0 || bus.ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: stall=%b rvalid=%b, required 0/0", bus.cpu_stall, bus.ext_rvalid);
    end
    n_checks++;
    if (bus.ext_gnt !== 1'b0 || bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b re=%b we=%b, required 0/0/0", bus.ext_gnt, bus.mem_re, bus.mem_we);
    end
    apply_reset();
  endtask

  task automatic test_cpu_rw();
    apply_reset();
    bus.cpu_we = 1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hBEEF;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.cpu_stall} !== {1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL cpu_write: we=%b re=%b a=%h d=%h stall=%b, required 1 0 0010 beef 0",
               bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.cpu_stall);
    end
    @(posedge clk); #1;
    bus.cpu_we = 0; bus.cpu_re = 1;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.cpu_stall} !== {1'b0, 1'b1, 16'h0010, 1'b0}) begin
      n_fail++;
      $display("FAIL cpu_read: we=%b re=%b a=%h stall=%b, required 0 1 0010 0",
               bus.mem_we, bus.mem_re, bus.mem_addr, bus.cpu_stall);
    end
    @(posedge clk); #1;
    bus.cpu_re = 0;
    @(negedge clk);
    n_checks++;
    if (bus.cpu_rdata !== 16'hBEEF || bus.cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_rdata: rdata=%h stall=%b, required beef 0", bus.cpu_rdata, bus.cpu_stall);
    end
  endtask

  task automatic test_ext_idle();
    apply_reset();
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 16'h0020; bus.ext_wdata = 16'h1234;
    @(negedge clk);
    n_checks++;
    if ({bus.ext_gnt, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234}) begin
      n_fail++;
      $display("FAIL ext_write: gnt=%b we=%b re=%b a=%h d=%h, required 1 1 0 0020 1234",
               bus.ext_gnt, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    bus.ext_we = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.ext_gnt, bus.mem_re, bus.mem_we, bus.ext_rvalid} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ext_read: gnt=%b re=%b we=%b rvalid=%b, required 1 1 0 0",
               bus.ext_gnt, bus.mem_re, bus.mem_we, bus.ext_rvalid);
    end
    @(posedge clk); #1;
    bus.ext_req = 0;
    @(negedge clk);
    n_checks++;
    if (bus.ext_rvalid !== 1'b1 || bus.ext_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL ext_rdata: rvalid=%b rdata=%h, required 1 1234", bus.ext_rvalid, bus.ext_rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_rvalid_pulse: rvalid=%b, required 0", bus.ext_rvalid);
    end
  endtask

  task automatic test_force();
    apply_reset();
    bus.cpu_re = 1; bus.cpu_addr = 16'h0030;
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 16'h0020;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        n_checks++;
        if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL force_blocked c%0d: gnt=%b stall=%b, required 0 0", k, bus.ext_gnt, bus.cpu_stall);
        end
      end else if (k == 8) begin
        n_checks++;
        if ({bus.cpu_stall, bus.ext_gnt, bus.mem_re, bus.mem_addr} !== {1'b1, 1'b1, 1'b1, 16'h0020}) begin
          n_fail++;
          $display("FAIL force_slot: stall=%b gnt=%b re=%b a=%h, required 1 1 1 0020",
                   bus.cpu_stall, bus.ext_gnt, bus.mem_re, bus.mem_addr);
        end
      end else begin
        n_checks++;
        if ({bus.ext_rvalid, bus.ext_rdata, bus.cpu_stall, bus.mem_re, bus.mem_addr} !==
            {1'b1, 16'h1234, 1'b0, 1'b1, 16'h0030}) begin
          n_fail++;
          $display("FAIL force_after: rvalid=%b rdata=%h stall=%b re=%b a=%h, required 1 1234 0 1 0030",
                   bus.ext_rvalid, bus.ext_rdata, bus.cpu_stall, bus.mem_re, bus.mem_addr);
        end
      end
      @(posedge clk); #1;
      if (k == 8) bus.ext_req = 0;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int grants;
    int stalls;
    int blocked;
    bit prev_stall;
    apply_reset();
    grants = 0; stalls = 0; blocked = 0; prev_stall = 0;
    bus.ext_req = 1; bus.ext_we = 1'($urandom); bus.ext_addr = 16'($urandom_range(0, 63));
    bus.cpu_re = 1;
    for (int k = 0; k < 90; k++) begin
      if (!prev_stall) begin
        bus.cpu_we   = 1'($urandom);
        bus.cpu_re   = !bus.cpu_we || 1'($urandom);
        bus.cpu_addr = 16'($urandom_range(0, 63));
        bus.cpu_wdata = 16'($urandom);
      end
      @(negedge clk);
      if (bus.cpu_stall) stalls++;
      n_checks++;
      if (prev_stall && bus.cpu_stall) begin
        n_fail++;
        $display("FAIL b2b_double_stall c%0d: stall=1 twice, required single cycle", k);
      end
      prev_stall = bus.cpu_stall;
      if (bus.ext_gnt) begin
        grants++;
        n_checks++;
        if (blocked != MAX_WAIT) begin
          n_fail++;
          $display("FAIL b2b_blocked c%0d: blocked=%0d, required %0d", k, blocked, MAX_WAIT);
        end
        blocked = 0;
      end else begin
        blocked++;
      end
      @(posedge clk); #1;
      if (bus.ext_gnt || prev_stall) begin
        bus.ext_we    = 1'($urandom);
        bus.ext_addr  = 16'($urandom_range(0, 63));
        bus.ext_wdata = 16'($urandom);
      end
    end
    @(negedge clk);
    n_checks++;
    if (grants != 10 || stalls != 10) begin
      n_fail++;
      $display("FAIL b2b_counts: grants=%0d stalls=%0d, required 10 10", grants, stalls);
    end
`ifdef DM_ARB_STATS_EN
    n_checks++;
    if (stat_ext_cnt !== 16'd10 || stat_stall_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL stats: ext=%0d stall=%0d, required 10 10", stat_ext_cnt, stat_stall_cnt);
    end
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    // Seed shadow from the memory stand-in so both start from the same image.
    for (int i = 0; i < 256; i++) shadow[i] = dm_mem[i];
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({bus.ext_gnt, bus.mem_re, bus.mem_we, bus.cpu_stall, bus.ext_rvalid} !==
          {exp_gnt, exp_re, exp_we, exp_stall, exp_rvalid}) begin
        n_fail++;
        $display("FAIL rand_ctrl c%0d: gnt/re/we/stall/rv=%b%b%b%b%b, required %b%b%b%b%b", k,
                 bus.ext_gnt, bus.mem_re, bus.mem_we, bus.cpu_stall, bus.ext_rvalid,
                 exp_gnt, exp_re, exp_we, exp_stall, exp_rvalid);
      end
      n_checks++;
      if (bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wdata) begin
        n_fail++;
        $display("FAIL rand_bus c%0d: a=%h d=%h, required a=%h d=%h", k,
                 bus.mem_addr, bus.mem_wdata, exp_addr, exp_wdata);
      end
      if (exp_rvalid) begin
        n_checks++;
        if (bus.ext_rdata !== m_rdata) begin
          n_fail++;
          $display("FAIL rand_rdata c%0d: rdata=%h, required %h", k, bus.ext_rdata, m_rdata);
        end
      end
      @(posedge clk);
      model_commit();
      #1;
      // CPU holds its request while stalled; ext holds until granted.
      if (!exp_stall) begin
        bus.cpu_re    = ($urandom_range(0, 99) < 45);
        bus.cpu_we    = ($urandom_range(0, 99) < 30);
        bus.cpu_addr  = 16'($urandom_range(0, 15));
        bus.cpu_wdata = 16'($urandom);
      end
      if (exp_gnt || !bus.ext_req) begin
        bus.ext_req   = ($urandom_range(0, 99) < 60);
        bus.ext_we    = 1'($urandom);
        bus.ext_addr  = 16'($urandom_range(0, 15));
        bus.ext_wdata = 16'($urandom);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_force();
    int first_stall;
    apply_reset();
    bus.cpu_re = 1; bus.cpu_addr = 16'h0030;
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 16'h0020;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (bus.cpu_stall !== 1'b1 || bus.ext_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstf_setup: stall=%b gnt=%b, required 1 1", bus.cpu_stall, bus.ext_gnt);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (bus.cpu_stall !== 1'b0 || bus.ext_rvalid !== 1'b0 || bus.ext_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rstf_clear: stall=%b rvalid=%b gnt=%b, required 0 0 0",
               bus.cpu_stall, bus.ext_rvalid, bus.ext_gnt);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.ext_rvalid !== 1'b0 || bus.mem_re !== 1'b0 || bus.ext_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL rstf_after c%0d: rvalid=%b re=%b gnt=%b, required 0 0 0",
                 k, bus.ext_rvalid, bus.mem_re, bus.ext_gnt);
      end
      @(posedge clk); #1;
    end
    // A fresh blocked request must wait the full MAX_WAIT cycles again.
    bus.cpu_re = 1; bus.ext_req = 1; bus.ext_we = 1;
    first_stall = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.cpu_stall && first_stall < 0) first_stall = k;
      @(posedge clk); #1;
    end
    n_checks++;
    if (first_stall != MAX_WAIT) begin
      n_fail++;
      $display("FAIL rstf_age: first stall cycle=%0d, required %0d", first_stall, MAX_WAIT);
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst_n = 1;
    #1;
    test_reset();
    test_cpu_rw();
    test_ext_idle();
    test_force();
    test_back_to_back();
    test_random();
    test_reset_mid_force();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
